// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// seq_magnitude_comparator: chunk-serial signed/unsigned magnitude compare,
// MSB chunk first, with start/busy/done handshake and registered flags.
// Revision: 1.0
// ============================================================================
module seq_magnitude_comparator #(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             result_vld,
  output logic             GREATER,
  output logic             EQUAL,
  output logic             LESS
);

  localparam int NCHUNK    = WIDTH / CHUNK;
  localparam int IDXW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int TOP_SHIFT = WIDTH - CHUNK;

  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx;
  logic             decided;
  logic             dec_gt;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             chunk_gt;
  logic             chunk_lt;
  logic             chunk_diff;
  logic             is_last;
  logic             finish;
  logic             fin_gt;
  logic             fin_lt;

  // Chunk idx counts from the MSB end; shifting right brings it to the bottom.
  assign chunk_a    = CHUNK'(a_q >> (TOP_SHIFT - CHUNK * int'(idx)));
  assign chunk_b    = CHUNK'(b_q >> (TOP_SHIFT - CHUNK * int'(idx)));
  assign chunk_gt   = (chunk_a > chunk_b);
  assign chunk_lt   = (chunk_a < chunk_b);
  assign chunk_diff = chunk_gt | chunk_lt;
  assign is_last    = (idx == LAST_IDX);

  always_comb begin
    finish = 1'b0;
    fin_gt = 1'b0;
    fin_lt = 1'b0;
    if (state == RUN) begin
      if (EARLY_EXIT && chunk_diff) begin
        finish = 1'b1;
        fin_gt = chunk_gt;
        fin_lt = chunk_lt;
      end else if (is_last) begin
        finish = 1'b1;
        // An earlier recorded decision outranks whatever the last chunk says.
        if (decided) begin
          fin_gt = dec_gt;
          fin_lt = ~dec_gt;
        end else begin
          fin_gt = chunk_gt;
          fin_lt = chunk_lt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      decided    <= 1'b0;
      dec_gt     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result_vld <= 1'b0;
      GREATER    <= 1'b0;
      EQUAL      <= 1'b0;
      LESS       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_q     <= signed_mode ? (a ^ SIGN_MASK) : a;
            b_q     <= signed_mode ? (b ^ SIGN_MASK) : b;
            idx     <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (finish) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            result_vld <= 1'b1;
            GREATER    <= fin_gt;
            LESS       <= fin_lt;
            EQUAL      <= ~(fin_gt | fin_lt);
          end else begin
            idx <= idx + 1'b1;
            if (!decided && chunk_diff) begin
              decided <= 1'b1;
              dec_gt  <= chunk_gt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
